output_buffer: RTL and testbench
================================

OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the entry width (one bfp32 result).
REQ-002 SHALL have parameter ADDR_W, default 4, the address width; depth is 2**ADDR_W (16 entries).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, write strobe from the upstream accumulator's output_buffer_enable.
REQ-006 SHALL have port wr_addr, input, ADDR_W, the write address from output_buffer_addr.
REQ-007 SHALL have port wr_data, input, DATA_W, the write data from output_data.
REQ-008 SHALL have port drain_start, input, 1, a pulse that requests a drain of all valid entries.
REQ-009 SHALL have port out_valid, output, 1, stream valid.
REQ-010 SHALL have port out_ready, input, 1, stream ready from the consumer.
REQ-011 SHALL have port out_data, output, DATA_W, stream data.
REQ-012 SHALL have port out_addr, output, ADDR_W, the entry address of out_data.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port drain_done, output, 1, a one-cycle pulse at the end of a drain.
REQ-015 SHALL have port overwrite, output, 1, a sticky flag set when a write hits an entry that is still valid.
REQ-016 SHALL have port count, output, ADDR_W+1, the number of valid entries (0..16).

Function
REQ-017 SHALL store wr_data in entry wr_addr and set that entry's valid bit on every cycle with wr_en=1, in any FSM state; the result is visible one cycle later.
REQ-018 SHALL implement the FSM states IDLE, SCAN, SEND and DONE.
REQ-019 IDLE: on drain_start=1, SHALL clear the pointer to 0 and go to SCAN; drain_start in any other state SHALL be ignored.
REQ-020 SCAN: SHALL examine one entry per cycle.
REQ-021 SCAN, entry valid: SHALL register the entry's pre-write contents into out_data/out_addr and go to SEND.
REQ-022 SCAN, entry invalid: SHALL go to DONE if the pointer is 15, otherwise increment the pointer.
REQ-023 SEND: out_valid SHALL be 1, and out_data/out_addr SHALL hold stable until out_valid and out_ready are both high.
REQ-024 SEND: on handshake SHALL clear the entry's valid bit, then go to DONE if the pointer is 15, otherwise increment the pointer and go to SCAN.
REQ-025 DONE: SHALL assert drain_done for exactly one cycle and return to IDLE.
REQ-026 On a same-cycle wr_en to the entry being cleared by handshake, the write SHALL win: the valid bit stays 1 with the new data, and the entry is not re-sent in this drain.
REQ-027 Writes during a drain to addresses above the pointer SHALL be sent in that drain; writes to addresses at or below the pointer SHALL remain valid for the next drain.
REQ-028 overwrite SHALL set when wr_en targets a valid entry that is not being cleared in the same cycle; it SHALL clear only on rst.
REQ-029 count SHALL track set/clear events; a simultaneous set and clear of different entries SHALL leave it unchanged, and it SHALL never exceed 16 or wrap.
REQ-030 Minimum drain latency SHALL be 17 cycles from drain_start to drain_done when the buffer is empty, and SHALL be one cycle longer per entry sent at out_ready=1.

Reset
REQ-031 rst SHALL take effect at any cycle, including mid-drain, and SHALL force: state IDLE; pointer 0; all valid bits 0; out_valid, busy, drain_done and overwrite 0; count 0; out_data and out_addr 0.
REQ-032 Entry data contents SHALL NOT require reset.
REQ-033 A wr_en in the same cycle as rst SHALL be discarded.

Configuration
REQ-034 With OUTBUF_OVW_COUNT_EN defined, the block SHALL add output ovw_count[7:0], a count of REQ-028 events that saturates at 255 and resets to 0.
REQ-035 Without OUTBUF_OVW_COUNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Write addr 3=0x3F800000 and addr 9=0x40000000, then drain_start with out_ready=1 -> exactly two beats, (3,0x3F800000) then (9,0x40000000); drain_done pulses; count goes 2->0.
REQ-037 Empty buffer, drain_start -> no out_valid; drain_done exactly 17 cycles after drain_start; busy high for 17 cycles.
REQ-038 Entry 5 valid, out_ready held low for 10 cycles in SEND -> out_valid and out_data stable for all 10 cycles; a single beat on release.
REQ-039 Handshake on entry 5 with a same-cycle write of 0x41200000 to entry 5 -> entry 5 stays valid and is sent in the next drain as 0x41200000; overwrite stays 0.
REQ-040 Write entry 7 twice without a drain -> overwrite=1 (and ovw_count=1 when enabled); rst asserted mid-drain -> all outputs 0 next cycle and count=0.

Source files
------------

// File: rtl/output_buffer.sv
// Result buffer of 2**ADDR_W entries with a valid-ordered drain stream.
// Optional feature macro: OUTBUF_OVW_COUNT_EN adds the saturating ovw_count output.
`timescale 1ns/1ps
module output_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              drain_start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              drain_done,
   output logic              overwrite,
`ifdef OUTBUF_OVW_COUNT_EN
   output logic [7:0]        ovw_count,
`endif
   output logic [ADDR_W:0]   count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST    = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [DEPTH-1:0]  valid;
   logic [DATA_W-1:0] mem [DEPTH];

   logic wr_hit_ptr, hs, clr, set_new, ovw_evt;

`ifdef OUTBUF_OVW_COUNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
`endif

   // A handshake clears the entry under the pointer unless a same-cycle write to it wins.
   always_comb begin
      wr_hit_ptr = wr_en && (wr_addr == ptr);
      hs         = (state == SEND) && out_ready;
      clr        = hs && !wr_hit_ptr;
      set_new    = wr_en && !valid[wr_addr];
      ovw_evt    = wr_en && valid[wr_addr] && !(hs && wr_hit_ptr);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (drain_start) state_nxt = SCAN;
         SCAN: begin
            if (valid[ptr])        state_nxt = SEND;
            else if (ptr == LAST)  state_nxt = DONE;
         end
         SEND: if (out_ready) state_nxt = (ptr == LAST) ? DONE : SCAN;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      out_valid  = (state == SEND);
      drain_done = (state == DONE);
   end

   // Entry storage carries no reset; a write coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         valid     <= '0;
         overwrite <= 1'b0;
         count     <= '0;
         out_data  <= '0;
         out_addr  <= '0;
      end else begin
         unique case (state)
            IDLE: if (drain_start) ptr <= '0;
            SCAN: begin
               if (valid[ptr]) begin
                  out_data <= mem[ptr];
                  out_addr <= ptr;
               end else if (ptr != LAST) begin
                  ptr <= ptr + PTR_ONE;
               end
            end
            SEND: if (out_ready && ptr != LAST) ptr <= ptr + PTR_ONE;
            default: ;
         endcase

         if (clr)   valid[ptr]     <= 1'b0;
         if (wr_en) valid[wr_addr] <= 1'b1;

         if (ovw_evt) overwrite <= 1'b1;

         unique case ({set_new, clr})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef OUTBUF_OVW_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)          ovw_count <= 8'd0;
      else if (ovw_evt) ovw_count <= sat_inc8(ovw_count);
   end
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed drain scenarios plus randomized
// write/drain rounds checked against an array model of the buffer contents.
`timescale 1ns/1ps
module tb_output_buffer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              drain_start = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              busy;
   logic              drain_done;
   logic              overwrite;
   logic [ADDR_W:0]   count;
`ifdef OUTBUF_OVW_COUNT_EN
   logic [7:0]        ovw_count;
`endif

   output_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .drain_start(drain_start), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .busy(busy), .drain_done(drain_done),
      .overwrite(overwrite),
`ifdef OUTBUF_OVW_COUNT_EN
      .ovw_count(ovw_count),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents, valid flags and sticky overwrite state.
   bit          ref_valid [DEPTH];
   logic [31:0] ref_data  [DEPTH];
   bit          ref_ovw;
   int          ref_ovc;

   logic [ADDR_W-1:0] got_addr [$];
   logic [DATA_W-1:0] got_data [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_count();
      int c = 0;
      for (int i = 0; i < DEPTH; i++) c += ref_valid[i];
      return c;
   endfunction

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
      ref_ovw = 1'b0;
      ref_ovc = 0;
   endtask

   task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      if (ref_valid[a]) begin
         ref_ovw = 1'b1;
         if (ref_ovc < 255) ref_ovc++;
      end
      ref_valid[a] = 1'b1;
      ref_data[a]  = d;
      tick();
      wr_en = 1'b0;
   endtask

   // mode 0: out_ready held high; mode 1: out_ready random each cycle.
   task automatic run_drain(input int mode, output int lat, output int busy_cyc,
                            output int stalls, output bit saw_valid);
      int cyc;
      lat = -1; busy_cyc = 0; stalls = 0; saw_valid = 1'b0;
      got_addr.delete(); got_data.delete();
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      cyc = 1;
      while (cyc <= 400) begin
         out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         if (busy) busy_cyc++;
         if (out_valid) saw_valid = 1'b1;
         if (out_valid && out_ready) begin
            got_addr.push_back(out_addr);
            got_data.push_back(out_data);
         end else if (out_valid) begin
            stalls++;
         end
         if (drain_done) begin
            lat = cyc;
            break;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      if (lat < 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: no drain_done within 400 cycles");
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({out_valid, busy, drain_done, overwrite, out_data, out_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b b=%b d=%b o=%b data=%h addr=%h, expected all 0",
                  out_valid, busy, drain_done, overwrite, out_data, out_addr);
      end
      n_tests++;
      if (count !== 5'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
      end
   endtask

   task automatic test_two_beats();
      int lat, bc, st; bit sv;
      do_reset();
      write_entry(4'd3, 32'h3F800000);
      write_entry(4'd9, 32'h40000000);
      n_tests++;
      if (count !== 5'd2) begin
         n_fail++; $display("FAIL two_count_before: got %0d expected 2", count);
      end
      run_drain(0, lat, bc, st, sv);
      n_tests++;
      if (got_addr.size() != 2) begin
         n_fail++; $display("FAIL two_beats: got %0d beats expected 2", got_addr.size());
      end else begin
         n_tests++;
         if ({got_addr[0], got_data[0], got_addr[1], got_data[1]} !==
             {4'd3, 32'h3F800000, 4'd9, 32'h40000000}) begin
            n_fail++;
            $display("FAIL two_beat_data: got (%0d,%h)(%0d,%h) expected (3,3f800000)(9,40000000)",
                     got_addr[0], got_data[0], got_addr[1], got_data[1]);
         end
      end
      n_tests++;
      if (lat != 19) begin
         n_fail++; $display("FAIL two_latency: got %0d expected 19", lat);
      end
      n_tests++;
      if (count !== 5'd0) begin
         n_fail++; $display("FAIL two_count_after: got %0d expected 0", count);
      end
      tick();
      n_tests++;
      if ({drain_done, busy} !== 2'b00) begin
         n_fail++; $display("FAIL two_done_pulse: got done=%b busy=%b expected 0 0", drain_done, busy);
      end
      for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
   endtask

   task automatic test_empty_drain();
      int lat, bc, st; bit sv;
      do_reset();
      run_drain(0, lat, bc, st, sv);
      n_tests++;
      if (lat != 17) begin
         n_fail++; $display("FAIL empty_latency: got %0d expected 17", lat);
      end
      n_tests++;
      if (bc != 17) begin
         n_fail++; $display("FAIL empty_busy: got %0d cycles expected 17", bc);
      end
      n_tests++;
      if (sv !== 1'b0) begin
         n_fail++; $display("FAIL empty_valid: got out_valid seen=%b expected 0", sv);
      end
   endtask

   task automatic test_stall();
      int cyc, extra; bit bad;
      do_reset();
      write_entry(4'd5, 32'hC0490FDB);
      drain_start = 1'b1; out_ready = 1'b0;
      tick();
      drain_start = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin tick(); cyc++; end
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || out_data !== 32'hC0490FDB || out_addr !== 4'd5) bad = 1'b1;
         tick();
      end
      n_tests++;
      if (bad) begin
         n_fail++; $display("FAIL stall_hold: got v=%b data=%h addr=%0d expected 1 c0490fdb 5 for 10 cycles",
                             out_valid, out_data, out_addr);
      end
      out_ready = 1'b1;
      tick();
      extra = 0; cyc = 0;
      while (!drain_done && cyc < 40) begin
         if (out_valid) extra++;
         tick(); cyc++;
      end
      out_ready = 1'b0;
      n_tests++;
      if (extra != 0 || drain_done !== 1'b1) begin
         n_fail++; $display("FAIL stall_single_beat: got extra=%0d done=%b expected 0 1", extra, drain_done);
      end
      n_tests++;
      if (count !== 5'd0) begin
         n_fail++; $display("FAIL stall_count: got %0d expected 0", count);
      end
      ref_valid[5] = 1'b0;
   endtask

   task automatic test_write_wins();
      int cyc, lat, bc, st; bit sv;
      do_reset();
      write_entry(4'd5, 32'h11111111);
      drain_start = 1'b1; out_ready = 1'b0;
      tick();
      drain_start = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin tick(); cyc++; end
      out_ready = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h41200000;
      tick();
      wr_en = 1'b0;
      ref_data[5] = 32'h41200000;
      cyc = 0; sv = 1'b0;
      while (!drain_done && cyc < 40) begin
         if (out_valid) sv = 1'b1;
         tick(); cyc++;
      end
      out_ready = 1'b0;
      n_tests++;
      if (sv !== 1'b0) begin
         n_fail++; $display("FAIL wins_no_resend: got out_valid again=%b expected 0", sv);
      end
      n_tests++;
      if ({overwrite, count} !== {1'b0, 5'd1}) begin
         n_fail++; $display("FAIL wins_flags: got ovw=%b count=%0d expected 0 1", overwrite, count);
      end
      tick();
      run_drain(0, lat, bc, st, sv);
      n_tests++;
      if (got_addr.size() != 1 || got_addr[0] !== 4'd5 || got_data[0] !== 32'h41200000) begin
         n_fail++;
         $display("FAIL wins_next_drain: got %0d beats first=(%0d,%h) expected 1 beat (5,41200000)",
                  got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : 4'd0,
                  (got_data.size() > 0) ? got_data[0] : 32'd0);
      end
      ref_valid[5] = 1'b0;
   endtask

   task automatic test_overwrite_reset();
      do_reset();
      write_entry(4'd7, 32'h3F000000);
      write_entry(4'd7, 32'h3E800000);
      n_tests++;
      if ({overwrite, count} !== {1'b1, 5'd1}) begin
         n_fail++; $display("FAIL ovw_flag: got ovw=%b count=%0d expected 1 1", overwrite, count);
      end
`ifdef OUTBUF_OVW_COUNT_EN
      n_tests++;
      if (ovw_count !== 8'd1) begin
         n_fail++; $display("FAIL ovw_count: got %0d expected 1", ovw_count);
      end
`endif
      write_entry(4'd1, 32'h01234567);
      write_entry(4'd12, 32'h89ABCDEF);
      drain_start = 1'b1; out_ready = 1'b0;
      tick();
      drain_start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hDEADBEEF;
      tick();
      rst = 1'b0; wr_en = 1'b0;
      n_tests++;
      if ({out_valid, busy, drain_done, overwrite, out_data, out_addr} !== '0 || count !== 5'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got v=%b b=%b d=%b o=%b data=%h addr=%h cnt=%0d expected all 0",
                  out_valid, busy, drain_done, overwrite, out_data, out_addr, count);
      end
`ifdef OUTBUF_OVW_COUNT_EN
      n_tests++;
      if (ovw_count !== 8'd0) begin
         n_fail++; $display("FAIL midreset_ovw_count: got %0d expected 0", ovw_count);
      end
`endif
      tick();
      n_tests++;
      if (count !== 5'd0) begin
         n_fail++; $display("FAIL reset_write_dropped: got count %0d expected 0", count);
      end
      for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
      ref_ovw = 1'b0; ref_ovc = 0;
   endtask

   task automatic test_random();
      int nw, lat, bc, st, nexp; bit sv;
      logic [ADDR_W-1:0] exp_addr [$];
      do_reset();
      for (int r = 0; r < 6; r++) begin
         nw = $urandom_range(1, 20);
         for (int k = 0; k < nw; k++)
            write_entry(ADDR_W'($urandom_range(0, DEPTH-1)), $urandom);
         n_tests++;
         if (count !== 5'(ref_count()) || overwrite !== ref_ovw) begin
            n_fail++; $display("FAIL rand_state r%0d: got cnt=%0d ovw=%b expected %0d %b",
                               r, count, overwrite, ref_count(), ref_ovw);
         end
`ifdef OUTBUF_OVW_COUNT_EN
         n_tests++;
         if (ovw_count !== 8'(ref_ovc)) begin
            n_fail++; $display("FAIL rand_ovw_count r%0d: got %0d expected %0d", r, ovw_count, ref_ovc);
         end
`endif
         exp_addr.delete();
         for (int i = 0; i < DEPTH; i++) if (ref_valid[i]) exp_addr.push_back(ADDR_W'(i));
         nexp = exp_addr.size();
         run_drain(1, lat, bc, st, sv);
         n_tests++;
         if (got_addr.size() != nexp) begin
            n_fail++; $display("FAIL rand_beats r%0d: got %0d expected %0d", r, got_addr.size(), nexp);
         end else begin
            for (int i = 0; i < nexp; i++) begin
               n_tests++;
               if (got_addr[i] !== exp_addr[i] || got_data[i] !== ref_data[exp_addr[i]]) begin
                  n_fail++; $display("FAIL rand_beat r%0d.%0d: got (%0d,%h) expected (%0d,%h)", r, i,
                                     got_addr[i], got_data[i], exp_addr[i], ref_data[exp_addr[i]]);
               end
            end
         end
         n_tests++;
         if (lat != 17 + nexp + st) begin
            n_fail++; $display("FAIL rand_latency r%0d: got %0d expected %0d", r, lat, 17 + nexp + st);
         end
         for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
         tick();
         n_tests++;
         if (count !== 5'd0) begin
            n_fail++; $display("FAIL rand_count_after r%0d: got %0d expected 0", r, count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_beats();
      test_empty_drain();
      test_stall();
      test_write_wins();
      test_overwrite_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
